// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - stream input and instruction-memory write bus for the boot loader
interface program_loader_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  imem_wr_en;
    logic [ADDR_WIDTH-1:0] imem_wr_addr;
    logic [DATA_WIDTH-1:0] imem_wr_data;

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_wr_en, imem_wr_addr, imem_wr_data
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_wr_en, imem_wr_addr, imem_wr_data
    );
endinterface

// File: rtl/program_loader.sv
// rtl/program_loader.sv - framed byte-stream loader for instruction memory; releases the core on a good checksum
module program_loader #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int BASE_ADDR      = 0,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    program_loader_if.slave       bus,
    output logic                  o_cpu_run,
    output logic                  o_done,
    output logic                  o_error,
    output logic [ADDR_WIDTH-1:0] o_load_count
);
    typedef enum logic [2:0] {IDLE, LEN, LOAD, CHECK, DONE, ERROR} state_t;

    localparam int LEN_LIMIT = (1 << ADDR_WIDTH) - BASE_ADDR;

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH:0]   r_count;
    logic [ADDR_WIDTH:0]   r_len;
    logic [DATA_WIDTH-1:0] r_sum;
    logic [31:0]           r_timer;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;

    logic                  w_rx_state;
    logic                  w_xfer;
    logic [31:0]           w_len32;
    logic                  w_len_bad;
    logic                  w_timeout;
    logic [ADDR_WIDTH:0]   w_count_inc;

    assign w_rx_state  = (r_state == LEN) || (r_state == LOAD) || (r_state == CHECK);
    assign w_xfer      = bus.in_valid && w_rx_state;
    assign w_len32     = 32'(bus.in_data);
    assign w_len_bad   = (w_len32 == 32'd0) || (w_len32 > 32'(LEN_LIMIT));
    assign w_count_inc = r_count + (ADDR_WIDTH+1)'(1);
    // A transfer in the limit cycle clears the timer instead of expiring it.
    assign w_timeout   = (TIMEOUT_CYCLES != 0) && !w_xfer &&
                         (r_timer >= 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE, DONE, ERROR: begin
                if (i_start) w_next_state = LEN;
            end
            LEN: begin
                if (w_xfer)         w_next_state = w_len_bad ? ERROR : LOAD;
                else if (w_timeout) w_next_state = ERROR;
            end
            LOAD: begin
                if (w_xfer) begin
                    if (w_count_inc == r_len) w_next_state = CHECK;
                end else if (w_timeout) begin
                    w_next_state = ERROR;
                end
            end
            CHECK: begin
                if (w_xfer)         w_next_state = (bus.in_data == r_sum) ? DONE : ERROR;
                else if (w_timeout) w_next_state = ERROR;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_count   <= '0;
            r_len     <= '0;
            r_sum     <= '0;
            r_timer   <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (w_rx_state) begin
                r_timer <= w_xfer ? 32'd0 : r_timer + 32'd1;
            end else if (i_start) begin
                r_count <= '0;
                r_sum   <= '0;
                r_timer <= '0;
            end
            if (w_xfer && r_state == LEN) begin
                r_len   <= w_len32[ADDR_WIDTH:0];
                r_count <= '0;
                r_sum   <= '0;
            end
            // Write is registered: strobe appears the cycle after the byte is accepted.
            if (w_xfer && r_state == LOAD) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= ADDR_WIDTH'(BASE_ADDR) + r_count[ADDR_WIDTH-1:0];
                r_wr_data <= bus.in_data;
                r_count   <= w_count_inc;
                r_sum     <= r_sum + bus.in_data;
            end
        end
    end

    assign bus.in_ready     = w_rx_state;
    assign bus.imem_wr_en   = r_wr_en;
    assign bus.imem_wr_addr = r_wr_addr;
    assign bus.imem_wr_data = r_wr_data;
    assign o_cpu_run        = (r_state == DONE);
    assign o_done           = (r_state == DONE);
    assign o_error          = (r_state == ERROR);
    assign o_load_count     = r_count[ADDR_WIDTH-1:0];
endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized self-checking bench for program_loader against a frame-level model
module tb_program_loader;
    typedef struct {
        int         c;
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sel;
    logic       tb_start;
    logic       tb_valid;
    logic [7:0] tb_data;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    wr_t        exp_q[$];
    logic [7:0] exp_mem [256];
    logic [7:0] dut_mem [256];
    logic [7:0] pl [256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    program_loader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus0 ();
    program_loader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus1 ();

    logic       start0, start1, run0, run1, done0, done1, err0, err1;
    logic [7:0] lc0, lc1;

    assign bus0.in_valid = tb_valid & ~sel;
    assign bus1.in_valid = tb_valid & sel;
    assign bus0.in_data  = tb_data;
    assign bus1.in_data  = tb_data;
    assign start0        = tb_start & ~sel;
    assign start1        = tb_start & sel;

    program_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .BASE_ADDR(0), .TIMEOUT_CYCLES(10)) dut0 (
        .i_clk(clk), .i_reset(rst_n), .i_start(start0), .bus(bus0.slave),
        .o_cpu_run(run0), .o_done(done0), .o_error(err0), .o_load_count(lc0)
    );

    program_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .BASE_ADDR(240), .TIMEOUT_CYCLES(0)) dut1 (
        .i_clk(clk), .i_reset(rst_n), .i_start(start1), .bus(bus1.slave),
        .o_cpu_run(run1), .o_done(done1), .o_error(err1), .o_load_count(lc1)
    );

    logic       m_ready, m_wr_en, m_run, m_done, m_err;
    logic [7:0] m_addr, m_wdata, m_lc;
    assign m_ready = sel ? bus1.in_ready     : bus0.in_ready;
    assign m_wr_en = sel ? bus1.imem_wr_en   : bus0.imem_wr_en;
    assign m_addr  = sel ? bus1.imem_wr_addr : bus0.imem_wr_addr;
    assign m_wdata = sel ? bus1.imem_wr_data : bus0.imem_wr_data;
    assign m_run   = sel ? run1  : run0;
    assign m_done  = sel ? done1 : done0;
    assign m_err   = sel ? err1  : err0;
    assign m_lc    = sel ? lc1   : lc0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Every strobe must match the oldest accepted payload byte, exactly one edge later.
    always @(negedge clk) begin
        if (m_wr_en) begin
            if (exp_q.size() == 0) begin
                check("spurious_wr", 1, 0);
            end else begin
                check("wr_cycle", cyc, exp_q[0].c);
                check("wr_addr", m_addr, exp_q[0].a);
                check("wr_data", m_wdata, exp_q[0].d);
                dut_mem[m_addr] = m_wdata;
                void'(exp_q.pop_front());
            end
        end else if (exp_q.size() != 0 && exp_q[0].c <= cyc) begin
            check("missing_wr", 0, 1);
            void'(exp_q.pop_front());
        end
    end

    task automatic do_start();
        tb_start = 1'b1;
        @(negedge clk);
        tb_start = 1'b0;
        check("start_run", m_run, 0);
        check("start_done", m_done, 0);
        check("start_err", m_err, 0);
        check("start_lc", m_lc, 0);
        check("start_ready", m_ready, 1);
    endtask

    task automatic put_byte(input logic [7:0] b, input int gap, input bit payload,
                            input int idx, output bit ok);
        wr_t e;
        ok = 1'b0;
        tb_valid = 1'b0;
        repeat (gap) @(negedge clk);
        tb_valid = 1'b1;
        tb_data  = b;
        for (int t = 0; t < 40 && !ok; t++) begin
            if (m_ready) begin
                ok = 1'b1;
                if (payload) begin
                    e.c = cyc + 1;
                    e.a = 8'(((sel ? 240 : 0) + idx) % 256);
                    e.d = b;
                    exp_q.push_back(e);
                end
            end
            @(negedge clk);
        end
        tb_valid = 1'b0;
        if (!ok) check("ready_wait", 0, 1);
    endtask

    task automatic run_frame(input logic [7:0] len, input bit good, input int glo,
                             input int ghi, input int stall);
        int         base;
        logic [7:0] sum;
        logic [7:0] cks;
        bit         ok;
        base = sel ? 240 : 0;
        do_start();
        put_byte(len, $urandom_range(ghi, glo), 0, 0, ok);
        if (len == 0 || base + int'(len) > 256) begin
            check("len_err", m_err, 1);
            check("len_err_done", m_done, 0);
            check("len_err_ready", m_ready, 0);
            return;
        end
        if (stall > 0) begin
            repeat (stall) @(negedge clk);
            check("stall_err", m_err, 0);
            check("stall_ready", m_ready, 1);
        end
        sum = 8'd0;
        for (int i = 0; i < int'(len); i++) begin
            put_byte(pl[i], $urandom_range(ghi, glo), 1, i, ok);
            sum = sum + pl[i];
            exp_mem[(base + i) % 256] = pl[i];
        end
        cks = good ? sum : sum + 8'd1;
        put_byte(cks, $urandom_range(ghi, glo), 0, 0, ok);
        check("end_done", m_done, good);
        check("end_err", m_err, !good);
        check("end_run", m_run, good);
        check("end_lc", m_lc, len);
        @(negedge clk);
        for (int i = 0; i < int'(len); i++)
            check("mem", dut_mem[(base + i) % 256], exp_mem[(base + i) % 256]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit         ok;
        logic [7:0] len;
        for (int i = 0; i < 256; i++) begin
            exp_mem[i] = 8'd0;
            dut_mem[i] = 8'd0;
        end
        rst_n = 1'b0; sel = 1'b0; tb_start = 1'b0; tb_valid = 1'b0; tb_data = 8'd0;
        #1;
        check("rst_ready", m_ready, 0);
        check("rst_wr_en", m_wr_en, 0);
        check("rst_run", m_run, 0);
        check("rst_done", m_done, 0);
        check("rst_err", m_err, 0);
        check("rst_lc", m_lc, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        pl[0] = 8'h41; pl[1] = 8'h82; pl[2] = 8'hC3;
        run_frame(8'd3, 1'b1, 0, 0, 0);
        run_frame(8'd3, 1'b0, 0, 0, 0);
        run_frame(8'd0, 1'b1, 0, 0, 0);

        // Timeout: ten idle cycles after the length byte expire the frame.
        do_start();
        put_byte(8'd2, 0, 0, 0, ok);
        repeat (9) @(negedge clk);
        check("to_before", m_err, 0);
        @(negedge clk);
        check("to_hit", m_err, 1);
        check("to_ready", m_ready, 0);

        // A byte accepted on the limit cycle keeps the frame alive.
        pl[0] = 8'h5A; pl[1] = 8'hA7;
        do_start();
        put_byte(8'd2, 0, 0, 0, ok);
        put_byte(pl[0], 9, 1, 0, ok);
        exp_mem[0] = pl[0];
        check("to_edge_err", m_err, 0);
        check("to_edge_ready", m_ready, 1);
        put_byte(pl[1], 0, 1, 1, ok);
        exp_mem[1] = pl[1];
        put_byte(pl[0] + pl[1], 0, 0, 0, ok);
        check("to_edge_done", m_done, 1);

        for (int k = 0; k < 8; k++) begin
            len = ($urandom_range(9, 0) == 0) ? 8'd0 : 8'($urandom_range(20, 1));
            for (int i = 0; i < 256; i++) pl[i] = 8'($urandom);
            run_frame(len, $urandom_range(3, 0) != 0, 0, 3, 0);
        end

        // Reset in the middle of a 4-byte frame.
        pl[0] = 8'h11; pl[1] = 8'h22;
        do_start();
        put_byte(8'd4, 0, 0, 0, ok);
        put_byte(pl[0], 0, 1, 0, ok);
        put_byte(pl[1], 0, 1, 1, ok);
        exp_mem[0] = pl[0]; exp_mem[1] = pl[1];
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_wr_en", m_wr_en, 0);
        check("mid_rst_ready", m_ready, 0);
        check("mid_rst_lc", m_lc, 0);
        check("mid_rst_err", m_err, 0);
        check("mid_rst_done", m_done, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        pl[0] = 8'hE1; pl[1] = 8'h0F; pl[2] = 8'h77;
        run_frame(8'd3, 1'b1, 0, 1, 0);

        // Restart from DONE with in_valid toggling every other cycle.
        check("pre_restart_run", m_run, 1);
        for (int i = 0; i < 256; i++) pl[i] = 8'($urandom);
        run_frame(8'd7, 1'b1, 1, 1, 0);

        // Second instance: BASE_ADDR=F0, timeout disabled.
        sel = 1'b1;
        run_frame(8'h11, 1'b1, 0, 0, 0);
        for (int i = 0; i < 256; i++) pl[i] = 8'($urandom);
        run_frame(8'h10, 1'b1, 0, 2, 30);
        run_frame(8'h02, 1'b0, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
Boot-time writer for the processor's instruction memory; the fetch side only reads that memory.
- Accepts a framed byte stream on a valid/ready interface: length byte, N instruction bytes, checksum byte.
- Writes the N bytes into instruction memory starting at BASE_ADDR.
- Releases the core (cpu_run, which feeds the datapath enable) only after the checksum matches.

Parameters:
ADDR_WIDTH, 8, instruction memory address width
DATA_WIDTH, 8, instruction/byte width
BASE_ADDR, 0, first instruction memory address written
TIMEOUT_CYCLES, 1000, max cycles without an accepted byte while in a receive state; 0 disables the timeout

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  begin a load frame (level; acted on only in IDLE/DONE/ERROR)
in_valid  input  1  in_data holds a byte
in_data  input  DATA_WIDTH  stream byte
in_ready  output  1  loader can accept a byte
imem_wr_en  output  1  instruction memory write strobe
imem_wr_addr  output  ADDR_WIDTH  instruction memory write address
imem_wr_data  output  DATA_WIDTH  instruction memory write data
cpu_run  output  1  core enable; high only in DONE
done  output  1  last frame loaded and verified
error  output  1  last frame failed (zero length, overflow, checksum, timeout)
load_count  output  ADDR_WIDTH  payload bytes written in current/last frame

Behaviour:
- Reset (reset low, asynchronous): state IDLE; all outputs 0; sum, count, length and timer cleared.
- States: IDLE, LEN, LOAD, CHECK, DONE, ERROR.
- Transfer: a byte moves only on a clk edge with in_valid=1 and in_ready=1. in_ready=1 exactly in LEN, LOAD and CHECK, and is a combinational decode of the registered state.
- IDLE: start=1 -> LEN.
- DONE and ERROR: start=1 -> LEN, clearing done, error, load_count and sum on that edge.
- start is ignored in LEN, LOAD and CHECK.
- LEN, on transfer:
  - length L = in_data.
  - L=0 -> ERROR.
  - BASE_ADDR+L > 2^ADDR_WIDTH -> ERROR.
  - otherwise -> LOAD with count=0, sum=0.
- LOAD, on transfer:
  - Registered write: on the next cycle imem_wr_en=1 for exactly one cycle, imem_wr_addr=BASE_ADDR+count, imem_wr_data=byte.
  - count and load_count increment; sum = (sum+byte) mod 256.
  - On the L-th byte -> CHECK.
  - Back-to-back transfers give back-to-back write strobes with consecutive addresses.
  - imem_wr_en is 0 in every other state or cycle.
- CHECK, on transfer: byte == sum -> DONE (done=1, cpu_run=1); otherwise -> ERROR (error=1).
- DONE: cpu_run=1, done=1 until start or reset. On start, cpu_run falls at the same edge the state enters LEN.
- ERROR: cpu_run=0, error=1. Already-written memory contents are not rolled back.
- Timeout:
  - The timer clears on entry to LEN and on every transfer, and counts each cycle in LEN/LOAD/CHECK without a transfer.
  - Reaching TIMEOUT_CYCLES -> ERROR.
  - A transfer in the same cycle the limit is reached wins: the timer clears and there is no error.
- Reset mid-frame: immediate return to IDLE. Any in-flight registered write is dropped, with imem_wr_en forced 0 asynchronously.
- Arithmetic: sum is DATA_WIDTH bits, wrapping. count is ADDR_WIDTH+1 bits internally so that L=2^ADDR_WIDTH-BASE_ADDR is reachable.
- done and error are never both 1.

Test Plan:
1. Frame 03,41,82,C3,86 after start -> three imem writes 41@00, 82@01, C3@02, each one cycle after its transfer; done=1, cpu_run=1, load_count=3.
2. Same frame with checksum 87 -> error=1, cpu_run=0, done=0; memory still holds the three bytes.
3. Length 00 -> ERROR on the next edge with no imem_wr_en. Separately, BASE_ADDR=F0 with length 11 -> ERROR.
4. TIMEOUT_CYCLES=10, send length 02 then idle 10 cycles -> error=1. A byte arriving on cycle 10 instead keeps the loader in LOAD.
5. reset pulled low after the second payload byte of a 4-byte frame -> all outputs 0 immediately. A fresh start then loads from address BASE_ADDR.
6. After a DONE, start with in_valid toggling every other cycle:
   - cpu_run drops at the start edge.
   - Writes occur only after accepted bytes.
   - The new frame ends in DONE with the correct load_count.
